// File: rtl/id_ex_register.sv
// ID/EX pipeline register: one-cycle latency; a stall or flush loads a bubble (never holds).
// Optional saturating stall counter on Stall_Count when STALL_COUNT_EN is defined.
// No backpressure: the upstream IF/ID register holds the stalled instruction.
module id_ex_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall_Control,
  input  logic        Flush_Ex,
  input  logic        Valid_D,
  input  logic [7:0]  Ctrl_D,
  input  logic [31:0] PC_D,
  input  logic [31:0] ReadData1_D,
  input  logic [31:0] ReadData2_D,
  input  logic [31:0] SignImm_D,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic [4:0]  Rd_D,
  output logic        Valid_Ex,
  output logic [7:0]  Ctrl_Ex,
  output logic [31:0] PC_Ex,
  output logic [31:0] ReadData1_Ex,
  output logic [31:0] ReadData2_Ex,
  output logic [31:0] SignImm_Ex,
  output logic [4:0]  Rs_Ex,
  output logic [4:0]  Rt_Ex,
  output logic [4:0]  Rd_Ex,
  output logic        MemRead_Ex
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0] Stall_Count
`endif
);

  typedef struct packed {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } ex_slot_t;

  ex_slot_t ex_d, ex_q;
  logic     bubble;

  assign bubble = Stall_Control | Flush_Ex;

  // An all-zero slot is the bubble: RegWrite, MemRead and MemWrite are all clear.
  always_comb begin
    ex_d = '0;
    if (!bubble) begin
      ex_d.valid = Valid_D;
      ex_d.ctrl  = Ctrl_D;
      ex_d.pc    = PC_D;
      ex_d.rd1   = ReadData1_D;
      ex_d.rd2   = ReadData2_D;
      ex_d.imm   = SignImm_D;
      ex_d.rs    = Rs_D;
      ex_d.rt    = Rt_D;
      ex_d.rd    = Rd_D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign Valid_Ex     = ex_q.valid;
  assign Ctrl_Ex      = ex_q.ctrl;
  assign PC_Ex        = ex_q.pc;
  assign ReadData1_Ex = ex_q.rd1;
  assign ReadData2_Ex = ex_q.rd2;
  assign SignImm_Ex   = ex_q.imm;
  assign Rs_Ex        = ex_q.rs;
  assign Rt_Ex        = ex_q.rt;
  assign Rd_Ex        = ex_q.rd;
  assign MemRead_Ex   = ex_q.ctrl[2];

`ifdef STALL_COUNT_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;

  // Flush-only cycles are not stalls and leave the count alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Stall_Control && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Bench for id_ex_register: directed steps plus random traffic against a value-level model.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Stall_Control, Flush_Ex, Valid_D;
  logic [7:0]  Ctrl_D;
  logic [31:0] PC_D, ReadData1_D, ReadData2_D, SignImm_D;
  logic [4:0]  Rs_D, Rt_D, Rd_D;
  logic        Valid_Ex, MemRead_Ex;
  logic [7:0]  Ctrl_Ex;
  logic [31:0] PC_Ex, ReadData1_Ex, ReadData2_Ex, SignImm_Ex;
  logic [4:0]  Rs_Ex, Rt_Ex, Rd_Ex;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each output should read now.
  int m_valid, m_ctrl, m_rs, m_rt, m_rd;
  logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
  int m_cnt;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .rst_n(rst_n), .Stall_Control(Stall_Control), .Flush_Ex(Flush_Ex),
    .Valid_D(Valid_D), .Ctrl_D(Ctrl_D), .PC_D(PC_D), .ReadData1_D(ReadData1_D),
    .ReadData2_D(ReadData2_D), .SignImm_D(SignImm_D), .Rs_D(Rs_D), .Rt_D(Rt_D), .Rd_D(Rd_D),
    .Valid_Ex(Valid_Ex), .Ctrl_Ex(Ctrl_Ex), .PC_Ex(PC_Ex), .ReadData1_Ex(ReadData1_Ex),
    .ReadData2_Ex(ReadData2_Ex), .SignImm_Ex(SignImm_Ex), .Rs_Ex(Rs_Ex), .Rt_Ex(Rt_Ex),
    .Rd_Ex(Rd_Ex), .MemRead_Ex(MemRead_Ex)
`ifdef STALL_COUNT_EN
    , .Stall_Count(stall_count)
`endif
  );

`ifndef STALL_COUNT_EN
  assign stall_count = 16'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {31'd0, Valid_Ex}, m_valid);
    chk({tag, ".ctrl"},  {24'd0, Ctrl_Ex}, m_ctrl);
    chk({tag, ".memrd"}, {31'd0, MemRead_Ex}, (m_ctrl >> 2) & 1);
    chk({tag, ".pc"},    PC_Ex, m_pc);
    chk({tag, ".rd1"},   ReadData1_Ex, m_rd1);
    chk({tag, ".rd2"},   ReadData2_Ex, m_rd2);
    chk({tag, ".imm"},   SignImm_Ex, m_imm);
    chk({tag, ".rs"},    {27'd0, Rs_Ex}, m_rs);
    chk({tag, ".rt"},    {27'd0, Rt_Ex}, m_rt);
    chk({tag, ".rd"},    {27'd0, Rd_Ex}, m_rd);
`ifdef STALL_COUNT_EN
    chk({tag, ".cnt"},   {16'd0, stall_count}, m_cnt);
`endif
  endtask

  task automatic model_reset();
    m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_cnt = 0;
  endtask

  // Rising edge: register either the ID instruction or an empty slot.
  task automatic model_edge();
    if (Stall_Control || Flush_Ex) begin
      m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
      m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
    end else begin
      m_valid = Valid_D; m_ctrl = Ctrl_D; m_rs = Rs_D; m_rt = Rt_D; m_rd = Rd_D;
      m_pc = PC_D; m_rd1 = ReadData1_D; m_rd2 = ReadData2_D; m_imm = SignImm_D;
    end
    if (Stall_Control) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic [7:0] c,
                       input logic [4:0] rt);
    @(negedge clk);
    Stall_Control = st; Flush_Ex = fl; Valid_D = v; Ctrl_D = c; Rt_D = rt;
    PC_D = $urandom; ReadData1_D = $urandom; ReadData2_D = $urandom; SignImm_D = $urandom;
    Rs_D = 5'($urandom); Rd_D = 5'($urandom);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    Stall_Control = 0; Flush_Ex = 0; Valid_D = 0; Ctrl_D = '0; PC_D = '0;
    ReadData1_D = '0; ReadData2_D = '0; SignImm_D = '0; Rs_D = '0; Rt_D = '0; Rd_D = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 1, 8'h07, 5'd9);
    step("load");

    drive(1, 0, 1, 8'h05, 5'd12);
    step("stall");
    @(negedge clk);
    Stall_Control = 0;
    step("unstall");

    drive(1, 1, 1, 8'h3F, 5'd3);
    step("stall_flush");

    drive(0, 1, 1, 8'hC4, 5'd4);
    step("flush");

    drive(0, 0, 0, 8'h00, 5'd5);
    step("invalid");

    drive(0, 0, 1, 8'hFF, 5'd31);
    step("load_ff");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    step("after_rst");

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 1'($urandom),
            8'($urandom), 5'($urandom));
      step("rand");
    end

`ifdef STALL_COUNT_EN
    drive(1, 0, 1, 8'h07, 5'd1);
    for (int i = 0; i < 65537; i++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    check_all("saturate");
    drive(0, 1, 1, 8'h07, 5'd2);
    step("flush_sat");
    drive(1, 0, 1, 8'h07, 5'd2);
    step("stall_sat");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port Stall_Control, input, 1: load-use stall request from hazard detection; 1 means insert a bubble.
REQ-004 SHALL have port Flush_Ex, input, 1: squash the instruction entering EX after a taken branch or jump.
REQ-005 SHALL have port Valid_D, input, 1: the ID-stage instruction is real, not a bubble.
REQ-006 SHALL have port Ctrl_D, input, 8: decoded controls; [0] RegWrite, [1] MemtoReg, [2] MemRead, [3] MemWrite, [4] ALUSrc, [5] RegDst, [7:6] ALUOp.
REQ-007 SHALL have port PC_D, input, 32: PC+4 of the ID instruction.
REQ-008 SHALL have port ReadData1_D, input, 32: register file port 1 data.
REQ-009 SHALL have port ReadData2_D, input, 32: register file port 2 data.
REQ-010 SHALL have port SignImm_D, input, 32: sign-extended immediate.
REQ-011 SHALL have ports Rs_D, Rt_D and Rd_D, each input, 5: register specifiers.
REQ-012 SHALL have port Valid_Ex, output, 1: the EX-stage slot holds a real instruction.
REQ-013 SHALL have port Ctrl_Ex, output, 8: registered Ctrl_D, same bit map.
REQ-014 SHALL have ports PC_Ex, ReadData1_Ex, ReadData2_Ex and SignImm_Ex, each output, 32: registered copies of the corresponding _D inputs.
REQ-015 SHALL have ports Rs_Ex, Rt_Ex and Rd_Ex, each output, 5: registered specifiers.
REQ-016 SHALL have port MemRead_Ex, output, 1: combinational copy of Ctrl_Ex[2], consumed by hazard detection.
REQ-017 SHALL have port Stall_Count, output, 16: count of stall cycles; present only when STALL_COUNT_EN is defined.

Function
REQ-018 SHALL have a latency of exactly one cycle: outputs on edge N+1 reflect the inputs sampled at edge N.
REQ-019 SHALL, on an edge with Stall_Control=0 and Flush_Ex=0, load every _Ex register from its _D input and load Valid_Ex from Valid_D.
REQ-020 SHALL, on an edge with Stall_Control=1 or Flush_Ex=1, load a bubble: Valid_Ex=0, Ctrl_Ex=8'h00, and every data and specifier output set to 0.
REQ-021 SHALL treat Stall_Control=1 and Flush_Ex=1 on the same edge as a single bubble, identical to REQ-020.
REQ-022 SHALL never hold its contents: a stall always produces a bubble, because the upstream IF/ID register holds the instruction itself.
REQ-023 SHALL guarantee that a bubble never asserts RegWrite, MemRead or MemWrite, so a bubble cannot retrigger a stall or commit state.
REQ-024 SHALL pass Ctrl_D through unmodified when Valid_D=0 and no bubble is forced; upstream zeroes the controls for invalid instructions.
REQ-025 SHALL have no internal combinational path from any input to any output.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, drive every output to 0, including Valid_Ex, Ctrl_Ex, MemRead_Ex and Stall_Count.
REQ-027 SHALL, when rst_n is asserted mid-stall, clear immediately; the first edge after rst_n deasserts obeys REQ-019 to REQ-021.

Configuration
REQ-028 SHALL, when STALL_COUNT_EN is defined, increment Stall_Count on each edge with Stall_Control=1, saturate at 16'hFFFF, and leave the count unchanged by Flush_Ex-only cycles.
REQ-029 SHALL, when STALL_COUNT_EN is undefined, omit both the Stall_Count port and the counter logic; all other behaviour is identical.

Verification
REQ-030 Bench SHALL apply Valid_D=1, Ctrl_D=8'h07, Rt_D=5'd9 with no stall -> one edge later Valid_Ex=1, Ctrl_Ex=8'h07, Rt_Ex=9, MemRead_Ex=1.
REQ-031 Bench SHALL apply Stall_Control=1 for one edge with Ctrl_D=8'h05 -> Valid_Ex=0, Ctrl_Ex=0, MemRead_Ex=0, Rt_Ex=0; the next unstalled edge loads the held instruction.
REQ-032 Bench SHALL apply Stall_Control=1 and Flush_Ex=1 together -> a single bubble, and with STALL_COUNT_EN defined Stall_Count increases by 1.
REQ-033 Bench SHALL pulse rst_n low between clock edges while data is loaded -> all outputs read 0 before the next edge.
REQ-034 Bench SHALL, with STALL_COUNT_EN defined, apply 65537 consecutive stall cycles -> Stall_Count=16'hFFFF held; a Flush_Ex-only cycle leaves it unchanged.
